// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - trap entry/exit sequencer: latch, prioritise, drain, strobe cause to CP0.
// Optional preemption timer is built only when TRAP_TIMER_PREEMPT_EN is defined.
module trap_controller #(
  parameter int TIMER_W      = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               kernel_mode,
  input  logic               exit_kernel,
  input  logic               syscall_req,
  input  logic               ovf_req,
  input  logic               timer_load,
  input  logic [TIMER_W-1:0] timer_value,
  output logic [2:0]         int_cause,
  output logic               cause_write,
  output logic               flush_pipe,
  output logic               stall_f,
  output logic [2:0]         pending,
  output logic [TIMER_W-1:0] timer_count
);

  typedef enum logic [1:0] {IDLE, DRAIN, TRAP, KERNEL} state_e;

  localparam logic [2:0] CAUSE_SYS = 3'b001;
  localparam logic [2:0] CAUSE_OVF = 3'b010;
  localparam logic [2:0] CAUSE_TMR = 3'b011;
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic [2:0] cause_q, cause_d;
  logic       cw_q, cw_d;
  logic [2:0] pending_q, pending_d;
  logic [2:0] clr;
  logic [2:0] win;
  logic       timer_fire;

`ifdef TRAP_TIMER_PREEMPT_EN
  logic [TIMER_W-1:0] slice_q, slice_d;
  logic [TIMER_W-1:0] count_q, count_d;

  // A load overrides a same-cycle decrement, including its reload/fire.
  always_comb begin
    slice_d    = slice_q;
    count_d    = count_q;
    timer_fire = 1'b0;
    if (timer_load) begin
      slice_d = timer_value;
      count_d = timer_value;
    end else if (state_q == IDLE && kernel_mode && count_q != '0) begin
      if (count_q == TIMER_W'(1)) begin
        timer_fire = 1'b1;
        count_d    = slice_q;
      end else begin
        count_d = count_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slice_q <= '0;
      count_q <= '0;
    end else begin
      slice_q <= slice_d;
      count_q <= count_d;
    end
  end

  assign timer_count = count_q;
`else
  logic unused_timer;
  assign unused_timer = ^{timer_load, timer_value};
  assign timer_fire   = 1'b0;
  assign timer_count  = '0;
`endif

  always_comb begin
    win = 3'b000;
    if (pending_q[1])      win = CAUSE_OVF;
    else if (pending_q[0]) win = CAUSE_SYS;
    else if (pending_q[2]) win = CAUSE_TMR;
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cause_d = cause_q;
    cw_d    = 1'b0;
    clr     = 3'b000;
    case (state_q)
      IDLE: begin
        if (kernel_mode && pending_q != 3'b000) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
          cause_d = win;
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d = TRAP;
          cw_d    = 1'b1;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      TRAP: begin
        state_d = KERNEL;
        clr[0]  = (cause_q == CAUSE_SYS);
        clr[1]  = (cause_q == CAUSE_OVF);
        clr[2]  = (cause_q == CAUSE_TMR);
      end
      KERNEL: begin
        if (exit_kernel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Fresh requests are OR-ed after the clear so a same-edge repeat stays pending.
    pending_d = (pending_q & ~clr) | {timer_fire, ovf_req, syscall_req};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      drain_q   <= 4'd0;
      cause_q   <= 3'b000;
      cw_q      <= 1'b0;
      pending_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cause_q   <= cause_d;
      cw_q      <= cw_d;
      pending_q <= pending_d;
    end
  end

  assign int_cause   = cause_q;
  assign cause_write = cw_q;
  assign pending     = pending_q;
  assign flush_pipe  = (state_q == DRAIN);
  assign stall_f     = (state_q == DRAIN) || (state_q == TRAP);

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - scoreboard bench for trap_controller.
module tb_trap_controller;
  localparam int D  = 2;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset, kernel_mode, exit_kernel, syscall_req, ovf_req, timer_load;
  logic [TW-1:0] timer_value;
  logic [2:0]    int_cause, pending;
  logic          cause_write, flush_pipe, stall_f;
  logic [TW-1:0] timer_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] cause;
    int         at;
  } exp_t;
  exp_t sb[$];

  trap_controller #(.TIMER_W(TW), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .kernel_mode(kernel_mode), .exit_kernel(exit_kernel),
    .syscall_req(syscall_req), .ovf_req(ovf_req), .timer_load(timer_load),
    .timer_value(timer_value), .int_cause(int_cause), .cause_write(cause_write),
    .flush_pipe(flush_pipe), .stall_f(stall_f), .pending(pending), .timer_count(timer_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected strobe: DRAIN entered on the next edge, visible D edges later.
  task automatic push(input logic [2:0] c);
    exp_t e;
    e.cause = c;
    e.at    = cyc + 1 + D;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && cause_write === 1'b1) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cause_write: int_cause %0h at cycle %0d, expected none", int_cause, cyc);
      end else begin
        e = sb.pop_front();
        if (int_cause !== e.cause || cyc != e.at) begin
          errors++;
          $display("FAIL trap_strobe: cause %0h cycle %0d, expected cause %0h cycle %0d",
                   int_cause, cyc, e.cause, e.at);
        end
      end
    end
  end

  task automatic finish_trap(input logic [2:0] exp_pend, input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_strobe_seen"}, sb.size(), 0);
    step();
    chk({name, "_kernel_pending"}, {29'd0, pending}, {29'd0, exp_pend});
    chk({name, "_kernel_stall"}, {31'd0, stall_f}, 0);
    kernel_mode = 1'b0;
    exit_kernel = 1'b1;
    step();
    exit_kernel = 1'b0;
    kernel_mode = 1'b1;
  endtask

  initial begin
    reset = 1'b1; kernel_mode = 1'b1; exit_kernel = 1'b0; syscall_req = 1'b0;
    ovf_req = 1'b0; timer_load = 1'b0; timer_value = '0;
    #1 reset = 1'b0;
    step(); step();
    chk("rst_int_cause", {29'd0, int_cause}, 0);
    chk("rst_cause_write", {31'd0, cause_write}, 0);
    chk("rst_flush", {31'd0, flush_pipe}, 0);
    chk("rst_stall", {31'd0, stall_f}, 0);
    chk("rst_pending", {29'd0, pending}, 0);
    chk("rst_timer_count", {16'd0, timer_count}, 0);
    reset = 1'b1;
    step();

    // Single syscall with drain timing
    syscall_req = 1'b1;
    step();
    syscall_req = 1'b0;
    chk("sys_pending", {29'd0, pending}, 32'h1);
    push(3'b001);
    for (int i = 0; i < D; i++) begin
      step();
      chk("sys_flush", {31'd0, flush_pipe}, 1);
      chk("sys_stall_drain", {31'd0, stall_f}, 1);
    end
    step();
    chk("sys_trap_flush", {31'd0, flush_pipe}, 0);
    chk("sys_trap_stall", {31'd0, stall_f}, 1);
    #1;
    finish_trap(3'b000, "sys");

    // Simultaneous overflow and syscall
    syscall_req = 1'b1; ovf_req = 1'b1;
    step();
    syscall_req = 1'b0; ovf_req = 1'b0;
    chk("both_pending", {29'd0, pending}, 32'h3);
    push(3'b010);
    finish_trap(3'b001, "ovf_first");
    push(3'b001);
    finish_trap(3'b000, "sys_second");

    // Overflow while already in kernel mode stays pending
    kernel_mode = 1'b0;
    ovf_req = 1'b1;
    step();
    ovf_req = 1'b0;
    chk("kmode_pending", {29'd0, pending}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("kmode_no_flush", {31'd0, flush_pipe}, 0);
    end
    kernel_mode = 1'b1;
    push(3'b010);
    finish_trap(3'b000, "kmode_ovf");

    // Reset in the middle of DRAIN
    syscall_req = 1'b1;
    step();
    syscall_req = 1'b0;
    step();
    chk("rd_in_drain", {31'd0, flush_pipe}, 1);
    #2 reset = 1'b0;
    #1;
    chk("rd_flush", {31'd0, flush_pipe}, 0);
    chk("rd_stall", {31'd0, stall_f}, 0);
    chk("rd_pending", {29'd0, pending}, 0);
    chk("rd_cause", {29'd0, int_cause}, 0);
    step(); step();
    reset = 1'b1;
    repeat (6) step();
    chk("rd_after_pending", {29'd0, pending}, 0);
    chk("rd_after_flush", {31'd0, flush_pipe}, 0);

`ifdef TRAP_TIMER_PREEMPT_EN
    timer_value = 16'd5; timer_load = 1'b1;
    step();
    timer_load = 1'b0;
    chk("tmr_load", {16'd0, timer_count}, 5);
    for (int v = 4; v >= 1; v--) begin
      step();
      chk("tmr_count", {16'd0, timer_count}, v);
    end
    step();
    chk("tmr_reload", {16'd0, timer_count}, 5);
    chk("tmr_pending", {29'd0, pending}, 32'h4);
    push(3'b011);
    for (int i = 0; i < D + 1; i++) begin
      step();
      chk("tmr_frozen", {16'd0, timer_count}, 4);
    end
    #1;
    finish_trap(3'b000, "tmr");
    chk("tmr_kernel_frozen", {16'd0, timer_count}, 4);
    timer_value = '0; timer_load = 1'b1;
    step();
    timer_load = 1'b0;
    repeat (8) step();
    chk("tmr_off_count", {16'd0, timer_count}, 0);
    chk("tmr_off_pending", {29'd0, pending}, 0);
`else
    timer_value = 16'd3; timer_load = 1'b1;
    step();
    timer_load = 1'b0;
    chk("notmr_count0", {16'd0, timer_count}, 0);
    repeat (10) step();
    chk("notmr_count", {16'd0, timer_count}, 0);
    chk("notmr_pending", {29'd0, pending}, 0);
    chk("notmr_flush", {31'd0, flush_pipe}, 0);
`endif

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
